// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, format encoding and parameter checks.
package decode_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREG x XLEN register file, x0 hardwired to zero, two combinational read ports.
// Optional forwarding of a same-edge write onto the read ports.
module decode_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]      regs_q [NREG];
  logic                 wr_hit;
  logic [1:0][4:0]      raddr;
  logic [1:0][XLEN-1:0] rdata;

  // Out-of-range indices are dropped rather than aliased onto low registers.
  assign wr_hit = we_i && (waddr_i != 5'd0) && (int'(waddr_i) < NREG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign raddr = {raddr2_i, raddr1_i};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if ((raddr[p] != 5'd0) && (int'(raddr[p]) < NREG)) begin
        rdata[p] = regs_q[raddr[p][AW-1:0]];
        if ((BYPASS != 0) && wr_hit && (waddr_i == raddr[p])) rdata[p] = wdata_i;
      end
    end
  end

  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

endmodule

// File: rtl/decode_unit.sv
// RV32 decode stage: one-cycle registered decode with valid/ready handshake.
// A stalled bundle keeps snooping writeback so its operands never go stale.
module decode_unit
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  if (!xlen_ok(XLEN) || !((NREG == 16) || (NREG == 32))) begin : g_bad_param
    $error("decode_unit: XLEN must be 32/64 and NREG 16/32");
  end

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  fmt_e            fmt_d;
  logic            use_rs1, use_rs2, use_rd, ill_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d, rf_rdata1, rf_rdata2;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            accept, wb_hit;

  always_comb begin
    fmt_d   = FMT_ILL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm32   = '0;
    case (inst_i[6:0])
      OP_REG: begin
        fmt_d = FMT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt_d = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_STORE: begin
        fmt_d = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_d = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U; use_rd = 1'b1;
        imm32 = {inst_i[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J; use_rd = 1'b1;
        imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: ;
    endcase

    ill_d = (fmt_d == FMT_ILL) || (inst_i[1:0] != 2'b11)
         || (use_rs1 && !in_range(inst_i[19:15]))
         || (use_rs2 && !in_range(inst_i[24:20]))
         || (use_rd  && !in_range(inst_i[11:7]));
    if (ill_d) fmt_d = FMT_ILL;

    rs1_d = (use_rs1 && !ill_d) ? inst_i[19:15] : 5'd0;
    rs2_d = (use_rs2 && !ill_d) ? inst_i[24:20] : 5'd0;
    rd_d  = (use_rd  && !ill_d) ? inst_i[11:7]  : 5'd0;
    imm_d = '0;
    if (!ill_d) imm_d = XLEN'($signed(imm32));
  end

  decode_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wb_en_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1_d),
    .raddr2_i (rs2_d),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign wb_hit     = wb_en_i && (wb_rd_i != 5'd0) && in_range(wb_rd_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      pc_o        <= '0;
      imm_o       <= '0;
      rdata1_o    <= '0;
      rdata2_o    <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rd_o        <= '0;
      fmt_o       <= FMT_R;
      illegal_o   <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      pc_o        <= pc_i;
      imm_o       <= imm_d;
      rdata1_o    <= ill_d ? '0 : rf_rdata1;
      rdata2_o    <= ill_d ? '0 : rf_rdata2;
      rs1_o       <= rs1_d;
      rs2_o       <= rs2_d;
      rd_o        <= rd_d;
      fmt_o       <= fmt_d;
      illegal_o   <= ill_d;
    end else if (out_valid_o) begin
      if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end else begin
        // Held bundle tracks writeback to its own source registers.
        if (wb_hit && (rs1_o != 5'd0) && (wb_rd_i == rs1_o)) rdata1_o <= wb_data_i;
        if (wb_hit && (rs2_o != 5'd0) && (wb_rd_i == rs2_o)) rdata2_o <= wb_data_i;
      end
    end
  end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath and register width; legal values 32 and 64.
REQ-002 The block SHALL have parameter NREG, default 32, architectural register count; legal values 16 (RV32E) and 32.
REQ-003 The block SHALL have parameter BYPASS, default 1, enabling same-cycle writeback forwarding into operand reads.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have these ports:
 - clk_i  in  1  clock
 - rst_i  in  1  asynchronous active-high reset
 - in_valid_i  in  1  instruction offered
 - in_ready_o  out  1  instruction accepted this cycle when high with in_valid_i
 - inst_i  in  32  instruction word
 - pc_i  in  XLEN  instruction address
 - wb_en_i  in  1  register write enable
 - wb_rd_i  in  5  write register index
 - wb_data_i  in  XLEN  write data
 - out_valid_o  out  1  decoded bundle valid
 - out_ready_i  in  1  consumer accepts bundle
 - pc_o  out  XLEN  registered pc
 - imm_o  out  XLEN  sign-extended immediate
 - rdata1_o, rdata2_o  out  XLEN  operands
 - rs1_o, rs2_o, rd_o  out  5 each  register indices
 - fmt_o  out  3  format code R/I/S/B/U/J/ILL
 - illegal_o  out  1  undecodable instruction

Function
REQ-006 The register file SHALL hold NREG x XLEN entries; x0 SHALL read zero and writes to it SHALL be discarded.
REQ-007 A write SHALL occur at posedge clk_i when wb_en_i=1, wb_rd_i!=0 and wb_rd_i<NREG; indices >=NREG SHALL be ignored.
REQ-008 in_ready_o SHALL equal (!out_valid_o || out_ready_i), combinationally.
REQ-009 On accept (in_valid_i && in_ready_o), all output registers SHALL load at the next edge and out_valid_o SHALL become 1; decode latency SHALL be exactly one cycle.
REQ-010 If out_valid_o && out_ready_i occurs with no accept, out_valid_o SHALL clear; while out_valid_o && !out_ready_i, the bundle SHALL hold, except as REQ-013 allows.
REQ-011 Formats SHALL be decoded by opcode:
 - R: 0110011
 - I: 0010011, 0000011, 1100111
 - S: 0100011
 - B: 1100011
 - U: 0110111, 0010111
 - J: 1101111
REQ-012 Each format SHALL drive rs1/rs2/rd as follows, with unused fields 0:
 - I: rs2=0
 - S, B: rd=0
 - U, J: rs1=rs2=0
 - R: imm=0
 - immediates SHALL sign-extend from bit 31 to XLEN
 - B and J immediates SHALL have bit0=0
 - U immediate SHALL be inst[31:12]<<12
REQ-013 While a bundle is held, a qualifying write matching nonzero rs1_o or rs2_o SHALL update the corresponding rdata at that edge.
REQ-014 With BYPASS=1, a same-edge write matching a nonzero accepted rs SHALL supply wb_data_i to that operand; with BYPASS=0 it SHALL supply the old value.
REQ-015 Any of the following SHALL set illegal_o=1, fmt_o=ILL, and force imm, rs1, rs2, rd and rdata to 0, while still being handshaked normally:
 - unknown opcode
 - inst[1:0]!=2'b11
 - any used register index >=NREG
REQ-016 Simultaneous accept and out_ready_i SHALL replace the bundle with out_valid_o remaining 1.

Reset
REQ-017 Asserting rst_i SHALL immediately and asynchronously clear:
 - all outputs, including out_valid_o and illegal_o
 - all registers
 - fmt_o, to R
REQ-018 During reset, writes and accepts SHALL be ignored; an instruction in flight SHALL be dropped.
REQ-019 After rst_i deasserts, in_ready_o SHALL be 1 at the first edge.

Structure
REQ-020 Package decode_pkg SHALL hold:
 - opcode constants
 - the fmt_o encoding (R=0, I=1, S=2, B=3, U=4, J=5, ILL=7)
 - the XLEN legality check
REQ-021 The register file SHALL be a sub-module decode_regfile with two combinational read ports, one write port and the BYPASS logic.

Verification
REQ-022 The bench SHALL cover each of these directed scenarios:
 - Write x5=0x0000_1234, then accept 0x00528333 (add x6,x5,x5) -> next cycle: out_valid_o=1, rdata1=rdata2=0x1234, rd_o=6, fmt_o=R.
 - Accept 0xFFF00093 (addi x1,x0,-1) with XLEN=64 -> imm_o=0xFFFF_FFFF_FFFF_FFFF, rs2_o=0.
 - Accept 0x00A28463 with out_ready_i=0, then write x5=0x99 -> held rdata1_o becomes 0x99; in_ready_o=0 until out_ready_i=1.
 - wb_en_i=1, wb_rd_i=7, wb_data_i=0x55 in the same cycle that an instruction reading x7 is accepted -> BYPASS=1 gives 0x55, BYPASS=0 gives the old value.
 - NREG=16, accept add x17,x1,x1 -> illegal_o=1, fmt_o=ILL, rdata=0; write to x20 is ignored.
 - Assert rst_i mid-stall -> out_valid_o=0 immediately; a subsequent read of x5 returns 0.
